// File: rtl/bulls_cows_core_if.sv
// Bulls-and-cows core bus: push-button and switch word in,
// score / status out. The core connects through the slave modport.
interface bulls_cows_core_if #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 15
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic                        confirma;
    logic [DIGITS*DIGIT_W-1:0]   sw;
    logic [CNT_W-1:0]            bulls;
    logic [CNT_W-1:0]            cows;
    logic [TRY_W-1:0]            tries;
    logic [2:0]                  state;
    logic                        result_valid;
    logic                        dup_err;
    logic                        win;
    logic                        lose;

    modport master (
        output confirma, sw,
        input  bulls, cows, tries, state, result_valid, dup_err, win, lose
    );

    modport slave (
        input  confirma, sw,
        output bulls, cows, tries, state, result_valid, dup_err, win, lose
    );
endinterface

// File: rtl/bulls_cows_core.sv
// Bulls-and-cows game core: a secret is set from the switches, then the
// player submits guesses until all digits match (WIN) or tries run out (LOSE).
// Optional push-button debounce filter enabled by macro BULLS_COWS_DEBOUNCE_EN.
module bulls_cows_core #(
    parameter int DIGITS          = 4,
    parameter int DIGIT_W         = 4,
    parameter int MAX_TRIES       = 15,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    bulls_cows_core_if.slave  bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int W     = DIGITS * DIGIT_W;

    typedef enum logic [2:0] {
        SET_SECRET = 3'd0,
        GUESS      = 3'd1,
        EVAL       = 3'd2,
        WIN        = 3'd3,
        LOSE       = 3'd4
    } state_t;

    if (DIGITS < 2 || DIGITS > 8 || MAX_TRIES < 1 || MAX_TRIES > 255 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("bulls_cows_core: parameter out of range");
    end

    state_t              state_q;
    logic [W-1:0]        secret_q;
    logic [W-1:0]        guess_q;
    logic [CNT_W-1:0]    bulls_q;
    logic [CNT_W-1:0]    cows_q;
    logic [TRY_W-1:0]    tries_q;
    logic                result_valid_q;
    logic                dup_err_q;
    logic                win_q;
    logic                lose_q;

    logic [1:0]          sync_q;
    logic [1:0]          warm_q;
    logic                armed_q;
    logic                level;
    logic                level_q;
    logic                cp;

    // Two-flop synchroniser plus edge-detector history. The edge detector is
    // only armed once a genuine low level has been seen after reset, so a
    // button held through reset release cannot fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            warm_q  <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.confirma};
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | (warm_q[1] & ~sync_q[1] & ~level);
            level_q <= level;
        end
    end

`ifdef BULLS_COWS_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt_q;
    logic            db_level_q;

    // Counter filter: the stable level follows the synchronised input only
    // after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else if (sync_q[1] == db_level_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_q   <= '0;
            db_level_q <= sync_q[1];
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign level = db_level_q;
`else
    assign level = sync_q[1];
`endif

    assign cp = armed_q & level & ~level_q;

    function automatic logic has_dup(input logic [W-1:0] word);
        logic dup;
        dup = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++)
            for (int unsigned j = i + 1; j < DIGITS; j++)
                if (word[i*DIGIT_W +: DIGIT_W] == word[j*DIGIT_W +: DIGIT_W])
                    dup = 1'b1;
        return dup;
    endfunction

    logic              sw_dup;
    logic [CNT_W-1:0]  bulls_n;
    logic [CNT_W-1:0]  cows_n;
    logic [TRY_W-1:0]  tries_n;

    // Score of the latched guess against the secret, and saturating try count.
    always_comb begin
        int unsigned b;
        int unsigned c;
        b = 0;
        c = 0;
        for (int unsigned i = 0; i < DIGITS; i++)
            for (int unsigned j = 0; j < DIGITS; j++)
                if (guess_q[i*DIGIT_W +: DIGIT_W] == secret_q[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) b++;
                    else        c++;
                end
        bulls_n = CNT_W'(b);
        cows_n  = CNT_W'(c);
        tries_n = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;
        sw_dup  = has_dup(bus.sw);
    end

    // Game FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= SET_SECRET;
            secret_q       <= '0;
            guess_q        <= '0;
            bulls_q        <= '0;
            cows_q         <= '0;
            tries_q        <= '0;
            result_valid_q <= 1'b0;
            dup_err_q      <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                SET_SECRET: if (cp) begin
                    if (sw_dup) begin
                        dup_err_q <= 1'b1;
                    end else begin
                        secret_q  <= bus.sw;
                        dup_err_q <= 1'b0;
                        bulls_q   <= '0;
                        cows_q    <= '0;
                        tries_q   <= '0;
                        state_q   <= GUESS;
                    end
                end
                GUESS: if (cp) begin
                    if (sw_dup) begin
                        dup_err_q <= 1'b1;
                    end else begin
                        guess_q   <= bus.sw;
                        dup_err_q <= 1'b0;
                        state_q   <= EVAL;
                    end
                end
                EVAL: begin
                    bulls_q        <= bulls_n;
                    cows_q         <= cows_n;
                    tries_q        <= tries_n;
                    result_valid_q <= 1'b1;
                    if (bulls_n == CNT_W'(DIGITS)) begin
                        win_q   <= 1'b1;
                        state_q <= WIN;
                    end else if (tries_n == TRY_W'(MAX_TRIES)) begin
                        lose_q  <= 1'b1;
                        state_q <= LOSE;
                    end else begin
                        state_q <= GUESS;
                    end
                end
                WIN, LOSE: if (cp) begin
                    win_q   <= 1'b0;
                    lose_q  <= 1'b0;
                    tries_q <= '0;
                    state_q <= SET_SECRET;
                end
                default: state_q <= SET_SECRET;
            endcase
        end
    end

    assign bus.bulls        = bulls_q;
    assign bus.cows         = cows_q;
    assign bus.tries        = tries_q;
    assign bus.state        = state_q;
    assign bus.result_valid = result_valid_q;
    assign bus.dup_err      = dup_err_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
endmodule

// File: tb/tb_bulls_cows_core.sv
// Directed self-checking bench for bulls_cows_core (DIGITS=4, DIGIT_W=4,
// MAX_TRIES=3, debounce disabled).
module tb_bulls_cows_core;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   rv_cnt;
    int   rv_before;
    bit   found;

    bulls_cows_core_if #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

    bulls_cows_core #(
        .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count result_valid pulses.
    initial rv_cnt = 0;
    always @(posedge clock) if (bus.result_valid === 1'b1) rv_cnt++;

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [15:0] v);
        bus.sw       = v;
        bus.confirma = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        bus.confirma = 1'b0;
        repeat (6) @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.confirma = 1'b0;
        bus.sw = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_bulls", bus.bulls, 0);
        chk("rst_cows",  bus.cows, 0);
        chk("rst_tries", bus.tries, 0);
        chk("rst_rv",    bus.result_valid, 0);
        chk("rst_dup",   bus.dup_err, 0);
        chk("rst_win",   bus.win, 0);
        chk("rst_lose",  bus.lose, 0);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // Duplicate secret rejected, then a valid one accepted.
        press(16'h1123);
        chk("dup_secret_err", bus.dup_err, 1);
        chk("dup_secret_state", bus.state, 0);
        press(16'h5678);
        chk("secret_ok_dup", bus.dup_err, 0);
        chk("secret_ok_state", bus.state, 1);
        press(16'h1223);
        chk("dup_guess_err", bus.dup_err, 1);
        chk("dup_guess_state", bus.state, 1);
        chk("dup_guess_tries", bus.tries, 0);
        rv_before = rv_cnt;
        press(16'h5678);
        chk("win1_rv", rv_cnt - rv_before, 1);
        chk("win1_bulls", bus.bulls, 4);
        chk("win1_cows", bus.cows, 0);
        chk("win1_tries", bus.tries, 1);
        chk("win1_win", bus.win, 1);
        chk("win1_state", bus.state, 3);
        chk("win1_dup", bus.dup_err, 0);
        press(16'h0000);
        chk("win1_exit_state", bus.state, 0);
        chk("win1_exit_win", bus.win, 0);
        chk("win1_exit_tries", bus.tries, 0);

        // Latency through EVAL on a 2-bull/2-cow guess.
        press(16'h1234);
        chk("s1234_state", bus.state, 1);
        rv_before = rv_cnt;
        bus.sw = 16'h1243;
        bus.confirma = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clock);
            #1;
            if (bus.state === 3'd2) found = 1'b1;
        end
        chk("eval_reached", found, 1);
        chk("eval_rv_low", bus.result_valid, 0);
        @(posedge clock);
        #1;
        chk("g1243_rv", bus.result_valid, 1);
        chk("g1243_bulls", bus.bulls, 2);
        chk("g1243_cows", bus.cows, 2);
        chk("g1243_tries", bus.tries, 1);
        chk("g1243_state", bus.state, 1);
        @(posedge clock);
        #1;
        chk("g1243_rv_pulse", bus.result_valid, 0);
        bus.confirma = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("g1243_rv_count", rv_cnt - rv_before, 1);
        press(16'h5678);
        chk("g5678_cows", bus.cows, 0);
        chk("g5678_tries", bus.tries, 2);
        press(16'h4321);
        chk("g4321_bulls", bus.bulls, 0);
        chk("g4321_cows", bus.cows, 4);
        chk("g4321_tries", bus.tries, 3);
        chk("g4321_lose", bus.lose, 1);
        chk("g4321_state", bus.state, 4);
        press(16'h0000);
        chk("lose_exit_state", bus.state, 0);
        chk("lose_exit_lose", bus.lose, 0);

        // Exact win path.
        press(16'h1234);
        press(16'h1234);
        chk("win2_bulls", bus.bulls, 4);
        chk("win2_cows", bus.cows, 0);
        chk("win2_win", bus.win, 1);
        chk("win2_state", bus.state, 3);
        press(16'h0000);
        chk("win2_exit_state", bus.state, 0);
        chk("win2_exit_tries", bus.tries, 0);

        // Exact lose path.
        press(16'h1234);
        rv_before = rv_cnt;
        press(16'h5678);
        press(16'h4321);
        press(16'h5679);
        chk("lose_rv_count", rv_cnt - rv_before, 3);
        chk("lose_tries", bus.tries, 3);
        chk("lose_bulls", bus.bulls, 0);
        chk("lose_cows", bus.cows, 0);
        chk("lose_lose", bus.lose, 1);
        chk("lose_state", bus.state, 4);
        press(16'h0000);
        chk("lose2_exit_state", bus.state, 0);

        // Win on the final allowed try takes priority over lose.
        press(16'h1234);
        press(16'h5678);
        press(16'h4321);
        press(16'h1234);
        chk("last_try_tries", bus.tries, 3);
        chk("last_try_win", bus.win, 1);
        chk("last_try_lose", bus.lose, 0);
        chk("last_try_state", bus.state, 3);
        press(16'h0000);

        // Reset during EVAL, with the button held through reset release.
        press(16'h1234);
        chk("pre_rst_state", bus.state, 1);
        rv_before = rv_cnt;
        bus.sw = 16'h1243;
        bus.confirma = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clock);
            #1;
            if (bus.state === 3'd2) found = 1'b1;
        end
        chk("rst_eval_reached", found, 1);
        reset = 1'b0;
        #1;
        chk("rst_eval_state", bus.state, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_eval_rv_count", rv_cnt - rv_before, 0);
        chk("rst_eval_bulls", bus.bulls, 0);
        chk("rst_eval_tries", bus.tries, 0);
        chk("rst_eval_win", bus.win, 0);
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("held_btn_no_cp", bus.state, 0);
        bus.confirma = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        press(16'h1234);
        chk("fresh_edge_cp", bus.state, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bulls_cows_core.md
BULLS_COWS_CORE -- requirements
Module: bulls_cows_core

Interface
REQ-001 Parameter DIGITS, default 4, number of digits in secret and guess (2..8).
REQ-002 Parameter DIGIT_W, default 4, bit width of one digit.
REQ-003 Parameter MAX_TRIES, default 15, number of guesses allowed before loss (1..255).
REQ-004 Parameter DEBOUNCE_CYCLES, default 100000, stable-level cycles required by the debounce filter.
REQ-005 clock  input  1  the block's only clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 confirma  input  1  raw, asynchronous push-button; a rising edge commits the switch value.
REQ-008 sw  input  DIGITS*DIGIT_W  switch word; digit k = sw[k*DIGIT_W +: DIGIT_W], digit DIGITS-1 is most significant.
REQ-009 bulls  output  $clog2(DIGITS+1)  registered count of right digit in right position.
REQ-010 cows  output  $clog2(DIGITS+1)  registered count of right digit in wrong position.
REQ-011 tries  output  $clog2(MAX_TRIES+1)  number of guesses evaluated since the last secret was set.
REQ-012 state  output  3  current FSM state code.
REQ-013 result_valid  output  1  single-cycle pulse when bulls, cows and tries update.
REQ-014 dup_err  output  1  last committed word was rejected for duplicate digits.
REQ-015 win  output  1  high while in WIN.
REQ-016 lose  output  1  high while in LOSE.

Function
REQ-017 confirma SHALL pass through a 2-flop synchroniser, then a rising-edge detector, to give a one-cycle pulse cp.
REQ-018 FSM states and codes SHALL be SET_SECRET=0, GUESS=1, EVAL=2, WIN=3, LOSE=4.
REQ-019 In SET_SECRET, cp with duplicate digits in sw SHALL set dup_err=1 and remain in SET_SECRET.
REQ-020 In SET_SECRET, cp with distinct digits SHALL latch sw as secret, clear dup_err, bulls, cows and tries, and go to GUESS.
REQ-021 In GUESS, cp with duplicate digits SHALL set dup_err=1, remain in GUESS and leave tries unchanged.
REQ-022 In GUESS, cp with distinct digits SHALL latch sw as guess, clear dup_err and go to EVAL.
REQ-023 EVAL SHALL last exactly one cycle; at its end bulls/cows register, tries increments by one, and result_valid pulses high for one cycle.
REQ-024 Bulls SHALL count positions i with guess[i]==secret[i].
REQ-025 Cows SHALL count pairs (i,j), i!=j, with guess[i]==secret[j]; bulls+cows never exceeds DIGITS.
REQ-026 From EVAL: if bulls==DIGITS, go to WIN; else if the incremented tries==MAX_TRIES, go to LOSE; else go to GUESS. The WIN test takes priority over the LOSE test on the last try.
REQ-027 Latency: cp asserted in GUESS at cycle t -> state=EVAL at t+1 -> result_valid, bulls, cows, tries and the next state valid at t+2.
REQ-028 cp during EVAL SHALL be ignored and is not queued.
REQ-029 In WIN or LOSE, bulls, cows and tries SHALL hold; cp SHALL go to SET_SECRET and clear win/lose; sw is not sampled on this cp.
REQ-030 tries SHALL saturate at MAX_TRIES and never wrap.

Reset
REQ-031 With reset low: state=SET_SECRET, bulls=0, cows=0, tries=0, result_valid=0, dup_err=0, win=0, lose=0, secret=0, guess=0, synchroniser and debounce registers=0.
REQ-032 Reset asserted mid-game, including during EVAL, SHALL abort immediately with no result_valid pulse.
REQ-033 A confirma held high through reset release SHALL NOT produce cp; a fresh rising edge is required.

Configuration
REQ-034 Macro BULLS_COWS_DEBOUNCE_EN defined: the synchronised confirma SHALL feed a counter filter that updates its stable level only after DEBOUNCE_CYCLES consecutive equal samples; the edge detector then uses the stable level, adding DEBOUNCE_CYCLES cycles of latency.
REQ-035 Macro BULLS_COWS_DEBOUNCE_EN undefined: no filter and no counter; the edge detector uses the synchroniser output directly.

Verification (DIGITS=4, DIGIT_W=4, MAX_TRIES=3, macro undefined)
REQ-036 Secret sw=16'h1234, then guess 16'h1243 -> result_valid pulse, bulls=2, cows=2, tries=1, state=GUESS.
REQ-037 Secret 16'h1234, then guess 16'h1234 -> bulls=4, cows=0, win=1, state=3; next cp -> state=0, tries=0.
REQ-038 Secret 16'h1123 -> dup_err=1, state=0; then 16'h5678 -> dup_err=0, state=1.
REQ-039 Secret 16'h1234, then guesses 16'h5678, 16'h4321, 16'h5679 -> third result has tries=3, lose=1, state=4; a further cp in LOSE leaves tries at 3 until return to SET_SECRET.
REQ-040 Reset pulsed low in the EVAL cycle -> no result_valid, all outputs at reset values, state=0; a confirma held high through reset release gives no cp.
